mem_arbiter: RTL and testbench

Shares the single multi-cycle unified memory between the pipeline's instruction-fetch port and data-memory port. Grants one access at a time, holds the memory interface stable for a fixed latency, returns read data with a one-cycle done pulse, and drives the per-port stall signals the pipeline uses to freeze IF or MEM.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one multi-cycle unified memory between the instruction-fetch port
// and the data-memory port. One access is in flight at a time. The memory
// interface is held stable for LATENCY cycles. A one-cycle done pulse follows
// each access, and the per-port stall signals freeze IF or MEM while their
// request is outstanding.
//
// Parameters
//   LATENCY  memory cycles per access (>= 1)
//   AW       address width
//   DW       data width
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_if_req/addr      fetch request (held with address until o_if_done)
//   o_if_rdata         last fetched word (registered)
//   o_if_done          one-cycle fetch completion pulse
//   o_if_stall         i_if_req & ~o_if_done
//   i_d_req/wr/addr/wdata  data request (held until o_d_done)
//   o_d_rdata          last loaded word (registered, loads only)
//   o_d_done           one-cycle data completion pulse
//   o_d_stall          i_d_req & ~o_d_done
//   o_mem_en/wr/addr/wdata  memory command, stable for the whole access
//   i_mem_rdata        memory read data, valid in the last access cycle
//   o_busy             arbiter not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATENCY = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    // instruction fetch port
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic [DW-1:0] o_if_rdata,
    output logic          o_if_done,
    output logic          o_if_stall,
    // data port
    input  logic          i_d_req,
    input  logic          i_d_wr,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_d_done,
    output logic          o_d_stall,
    // memory side
    output logic          o_mem_en,
    output logic          o_mem_wr,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    // status
    output logic          o_busy
);

    // Counter needs at least one bit even when LATENCY == 1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_grant_d;    // 1: data port owns the access, 0: fetch port
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_if_done;
    logic          r_d_done;

    logic          w_arb_slot;   // cycle in which a new request may be granted
    logic          w_access;
    logic          w_last;       // final memory cycle of the current access
    logic          w_any_req;

    // -------------------------------------------------------------------------
    // Next-state and decoded controls
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_access    = (r_state == ST_ACCESS);
        w_arb_slot  = (r_state == ST_IDLE) || (r_state == ST_RESP);
        w_last      = (r_cnt == CNT_LAST);
        w_any_req   = i_d_req | i_if_req;

        unique case (r_state)
            // RESP re-arbitrates in the same cycle, so back-to-back accesses
            // only lose the single response cycle.
            ST_IDLE, ST_RESP: w_state_nxt = w_any_req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS:        if (w_last) w_state_nxt = ST_RESP;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // -------------------------------------------------------------------------
    // Grant latch, latency counter, read-data capture, done flags
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_d  <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;

            if (w_arb_slot) begin
                r_cnt <= '0;
                // Data wins: the load/store belongs to an older instruction
                // than the one being fetched.
                if (i_d_req) begin
                    r_grant_d <= 1'b1;
                    r_addr    <= i_d_addr;
                    r_wr      <= i_d_wr;
                    r_wdata   <= i_d_wdata;
                end else if (i_if_req) begin
                    r_grant_d <= 1'b0;
                    r_addr    <= i_if_addr;
                    r_wr      <= 1'b0;
                end
            end else if (w_access) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cnt <= '0;
                    // Read data is captured even for a withdrawn request; only
                    // the done pulse is suppressed when the requester has gone.
                    if (r_grant_d) begin
                        if (!r_wr) r_d_rdata <= i_mem_rdata;
                        r_d_done <= i_d_req;
                    end else begin
                        r_if_rdata <= i_mem_rdata;
                        r_if_done  <= i_if_req;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_mem_en    = w_access;
    assign o_mem_wr    = w_access & r_wr;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_if_done   = r_if_done;
    assign o_d_done    = r_d_done;

    assign o_if_stall  = i_if_req & ~r_if_done;
    assign o_d_stall   = i_d_req  & ~r_d_done;

    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives directed scenarios followed by randomized fetch/data traffic with
// occasional resets. A transaction-level model (age of the current access,
// plus a reference memory array) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int L  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          d_req, d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_done, d_stall;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(L), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_rdata(if_rdata), .o_if_done(if_done), .o_if_stall(if_stall),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_done(d_done), .o_d_stall(d_stall),
    .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // initial memory contents, with the words the directed scenarios rely on
  function automatic logic [DW-1:0] init_word(input int i);
    case (i)
      8'h10:   return 16'hA5A5;
      8'h00:   return 16'h00FF;
      8'h04:   return 16'h1111;
      default: return DW'(i * 16'h9E37 ^ 16'h5A5A);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Environment memory: data is only valid in the last access cycle, and a
  // store commits at the end of its access (an abandoned store never lands).
  // ---------------------------------------------------------------------------
  logic [DW-1:0] env_mem [256];
  logic          env_ok = 1'b0;
  int            en_cnt = 0;

  always @(posedge clk) begin
    if (!env_ok) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      env_ok <= 1'b1;
    end else if (mem_en && mem_wr && en_cnt == L-1) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
    end
    en_cnt <= mem_en ? en_cnt + 1 : 0;
  end

  assign mem_rdata = (en_cnt == L-1) ? env_mem[mem_addr[7:0]] : ~env_mem[mem_addr[7:0]];

  // ---------------------------------------------------------------------------
  // Reference model: age 0 = idle, 1..L = memory cycles, L+1 = response cycle
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ref_mem [256];
  int            age = 0;
  logic          m_d = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rd = '0, m_d_rd = '0;
  logic          m_if_done = 1'b0, m_d_done = 1'b0;

  // apply the edge that just happened, using the inputs held in the last cycle
  task automatic model_edge();
    m_if_done = 1'b0;
    m_d_done  = 1'b0;
    if (rst) begin
      age = 0; m_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
      m_if_rd = '0; m_d_rd = '0;
    end else if (age >= 1 && age <= L) begin
      if (age == L) begin
        if (m_wr)     ref_mem[m_addr[7:0]] = m_wdata;
        else if (m_d) m_d_rd  = ref_mem[m_addr[7:0]];
        else          m_if_rd = ref_mem[m_addr[7:0]];
        if (m_d) m_d_done  = d_req;
        else     m_if_done = if_req;
      end
      age++;
    end else begin
      if (d_req) begin
        age = 1; m_d = 1; m_addr = d_addr; m_wr = d_wr; m_wdata = d_wdata;
      end else if (if_req) begin
        age = 1; m_d = 0; m_addr = if_addr; m_wr = 0;
      end else begin
        age = 0;
      end
    end
  endtask

  task automatic tick();
    logic en_e;
    @(posedge clk);
    #1;
    model_edge();
    en_e = (age >= 1 && age <= L);
    chk("busy",     busy,     age != 0);
    chk("mem_en",   mem_en,   en_e);
    chk("mem_wr",   mem_wr,   en_e & m_wr);
    chk("mem_addr", mem_addr, m_addr);
    if (en_e && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_done",  if_done,  m_if_done);
    chk("d_done",   d_done,   m_d_done);
    chk("if_rdata", if_rdata, m_if_rd);
    chk("d_rdata",  d_rdata,  m_d_rd);
  endtask

  // let freshly driven inputs settle, then check the combinational stalls
  task automatic settle();
    #1;
    chk("if_stall", if_stall, if_req & ~m_if_done);
    chk("d_stall",  d_stall,  d_req & ~m_d_done);
  endtask

  task automatic idle(input int n);
    if_req = 0; d_req = 0;
    for (int i = 0; i < n; i++) begin tick(); settle(); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 3; i++) tick();
    rst = 0;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_if_rd", if_rdata, 0);
    chk("rst_d_rd", d_rdata, 0);
    idle(2);

    // single fetch
    if_req = 1; if_addr = 16'h0010; settle();
    chk("t1_stall0", if_stall, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t1_en", mem_en, k <= 4);
      if (k == 5) begin
        chk("t1_done", if_done, 1);
        chk("t1_rd", if_rdata, 16'hA5A5);
        chk("t1_stall5", if_stall, 0);
        if_req = 0;
      end
      settle();
    end
    idle(2);

    // simultaneous load and fetch: data first
    d_req = 1; d_wr = 0; d_addr = 16'h0200; if_req = 1; if_addr = 16'h0004; settle();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) begin
        chk("t2_ddone", d_done, 1); chk("t2_drd", d_rdata, 16'h00FF); d_req = 0;
      end
      if (k >= 6 && k <= 9) chk("t2_addr", mem_addr, 16'h0004);
      if (k == 10) begin
        chk("t2_idone", if_done, 1); chk("t2_ird", if_rdata, 16'h1111); if_req = 0;
      end
      settle();
    end
    idle(2);

    // store, then read it back
    d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'h1234; settle();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin chk("t3_wr", mem_wr, 1); chk("t3_wd", mem_wdata, 16'h1234); end
      if (k == 5) begin
        chk("t3_done", d_done, 1); chk("t3_rd_keep", d_rdata, 16'h00FF);
        d_wr = 0;  // held request becomes a load of the same address
      end
      settle();
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) begin chk("t3_rb", d_rdata, 16'h1234); d_req = 0; end
      settle();
    end
    idle(2);

    // fetch withdrawn mid-access
    if_req = 1; if_addr = 16'h0020; settle();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) if_req = 0;
      chk("t4_en", mem_en, k <= 4);
      if (k == 5) chk("t4_nodone", if_done, 0);
      if (k == 6) chk("t4_busy", busy, 0);
      settle();
    end
    idle(1);

    // reset in the middle of a store, then a normal load
    d_req = 1; d_wr = 1; d_addr = 16'h0030; d_wdata = 16'hBEEF; settle();
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) rst = 1;
      if (k == 4) begin
        chk("t5_en", mem_en, 0); chk("t5_busy", busy, 0); chk("t5_drd", d_rdata, 0);
        rst = 0; d_wr = 0; d_addr = 16'h0030;
      end
      if (k == 9) begin
        chk("t5_done", d_done, 1);
        chk("t5_rd", d_rdata, init_word(8'h30));
        d_req = 0;
      end
      settle();
    end
    idle(2);

    // data request held high across two loads
    d_req = 1; d_wr = 0; d_addr = 16'h0010; settle();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_en", mem_en, k <= 9 && k != 5);
      if (k == 5 || k == 10) chk("t6_done", d_done, 1);
      if (k == 10) d_req = 0;
      settle();
    end
    idle(2);

    // randomized traffic with flushes, held requests and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      if (if_req) begin
        if (m_if_done) begin
          if_req = ($urandom_range(0, 2) == 0);
          if_addr = AW'($urandom);
        end else if ($urandom_range(0, 39) == 0) begin
          if_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = AW'($urandom);
      end
      if (d_req) begin
        if (m_d_done) begin
          d_req = ($urandom_range(0, 2) == 0);
          d_wr = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
        end else if ($urandom_range(0, 39) == 0) begin
          d_req = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        d_req = 1; d_wr = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
      end
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
